// File: rtl/wb_dest_ctrl.sv
// wb_dest_ctrl: multicycle writeback sequencer for the register-file write port.
//
// An instruction is classified on the cycle `start` is accepted. The
// sequencer waits out memory latency for loads and pop, drives the
// destination / write-data mux selects with the RegWrite strobe, and pulses
// `done` to the main control unit. Pop performs two writes back to back
// (rt from memory, then sp from the ALU).
//
// Optional build macro: WB_STALL_EN adds a `stall` input that freezes the
// sequencer and suppresses its strobes until it drops.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; returns the FSM to IDLE
//   stall      in   (WB_STALL_EN only) hold state, suppress strobes
//   start      in   one-cycle request; opcode/funct sampled with it
//   opcode     in   [5:0] instruction[31:26]
//   funct      in   [5:0] instruction[5:0], used only for opcode 0
//   wr_sel     out  [1:0] destination: 00 rt, 01 sp, 10 ra, 11 rd
//   wd_sel     out  [1:0] data: 00 alu, 01 mem, 10 pc, 11 imm<<16
//   reg_write  out  register-file write enable, one cycle per write
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   illegal    out  one-cycle pulse alongside done for unknown opcodes
//
// Handshake: `start` is a single-cycle request with no ready signal. It is
// accepted only in IDLE (and, with WB_STALL_EN, only while stall=0); at any
// other time it is ignored and the latched class is left untouched. `busy`
// tells the requester that a request would currently be dropped.

module wb_dest_ctrl #(
  parameter int unsigned MEM_WAIT = 2,
  parameter logic [5:0]  OP_PUSH  = 6'h1e,
  parameter logic [5:0]  OP_POP   = 6'h1f
) (
  input  logic       clk,
  input  logic       reset,
`ifdef WB_STALL_EN
  input  logic       stall,
`endif
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] wr_sel,
  output logic [1:0] wd_sel,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_MEM = 3'd1;
  localparam logic [2:0] S_WRITE1   = 3'd2;
  localparam logic [2:0] S_WRITE2   = 3'd3;
  localparam logic [2:0] S_FIN      = 3'd4;

  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_SINGLE = 2'd1;
  localparam logic [1:0] K_LOAD   = 2'd2;
  localparam logic [1:0] K_POP    = 2'd3;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_SP = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] DST_RD = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;

  localparam logic [2:0] MEM_WAIT_C = 3'(MEM_WAIT);

  logic stall_w;
`ifdef WB_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] wr_q, wr_d;
  logic [1:0] wd_q, wd_d;
  logic       pop_q, pop_d;
  logic       ill_q, ill_d;

  // Instruction classification.
  logic [1:0] dec_kind;
  logic [1:0] dec_wr;
  logic [1:0] dec_wd;
  logic       dec_ill;

  always_comb begin
    dec_kind = K_NONE;
    dec_wr   = DST_RT;
    dec_wd   = WD_ALU;
    dec_ill  = 1'b0;
    if (opcode == 6'h00) begin
      // jr, mult and div produce no register-file write.
      if (funct == 6'h08 || funct == 6'h18 || funct == 6'h1a) begin
        dec_kind = K_NONE;
      end else begin
        dec_kind = K_SINGLE;
        dec_wr   = DST_RD;
      end
    end else if (opcode == OP_PUSH) begin
      dec_kind = K_SINGLE;
      dec_wr   = DST_SP;
    end else if (opcode == OP_POP) begin
      // First write of pop is rt <- mem; the sp write is fixed in WRITE2.
      dec_kind = K_POP;
      dec_wd   = WD_MEM;
    end else begin
      case (opcode)
        6'h08, 6'h09, 6'h0a, 6'h0c: dec_kind = K_SINGLE;
        6'h0f: begin
          dec_kind = K_SINGLE;
          dec_wd   = WD_IMM;
        end
        6'h23, 6'h21, 6'h20: begin
          dec_kind = K_LOAD;
          dec_wd   = WD_MEM;
        end
        6'h2b, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02: dec_kind = K_NONE;
        6'h03: begin
          dec_kind = K_SINGLE;
          dec_wr   = DST_RA;
          dec_wd   = WD_PC;
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Next-state logic. A stall freezes the FSM, the wait counter and the
  // latched class in one place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    pop_d   = pop_q;
    ill_d   = ill_q;
    if (!stall_w) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wr_d  = dec_wr;
            wd_d  = dec_wd;
            pop_d = (dec_kind == K_POP);
            ill_d = dec_ill;
            case (dec_kind)
              K_NONE:   state_d = S_FIN;
              K_SINGLE: state_d = S_WRITE1;
              default: begin
                if (MEM_WAIT_C == 3'd0) begin
                  state_d = S_WRITE1;
                end else begin
                  state_d = S_WAIT_MEM;
                  cnt_d   = MEM_WAIT_C;
                end
              end
            endcase
          end
        end
        S_WAIT_MEM: begin
          // Counter holds the number of wait cycles still to spend,
          // including this one; leave when this is the last.
          if (cnt_q <= 3'd1) begin
            state_d = S_WRITE1;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_WRITE1: state_d = pop_q ? S_WRITE2 : S_IDLE;
        S_WRITE2: state_d = S_IDLE;
        S_FIN:    state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state; the mux selects read 00 whenever no
  // write is being issued.
  always_comb begin
    wr_sel    = DST_RT;
    wd_sel    = WD_ALU;
    reg_write = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = (state_q != S_IDLE);
    if (!stall_w) begin
      case (state_q)
        S_WRITE1: begin
          reg_write = 1'b1;
          wr_sel    = wr_q;
          wd_sel    = wd_q;
          done      = !pop_q;
        end
        S_WRITE2: begin
          reg_write = 1'b1;
          wr_sel    = DST_SP;
          wd_sel    = WD_ALU;
          done      = 1'b1;
        end
        S_FIN: begin
          done    = 1'b1;
          illegal = ill_q;
        end
        default: begin
          reg_write = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= DST_RT;
      wd_q    <= WD_ALU;
      pop_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      pop_q   <= pop_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_wb_dest_ctrl.sv
// Testbench for wb_dest_ctrl. A reference model turns each instruction into
// the list of per-cycle outputs the class table and latency rules imply;
// each test compares the sampled outputs against that list.
// Output vector layout: {busy, reg_write, wr_sel[1:0], wd_sel[1:0], done, illegal}.

module tb_wb_dest_ctrl;

  localparam int         MW      = 2;
  localparam logic [5:0] OP_PUSH = 6'h1e;
  localparam logic [5:0] OP_POP  = 6'h1f;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
`ifdef WB_STALL_EN
  logic       stall;
`endif
  logic [1:0] wr_sel;
  logic [1:0] wd_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       illegal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_dest_ctrl #(
    .MEM_WAIT (MW),
    .OP_PUSH  (OP_PUSH),
    .OP_POP   (OP_POP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef WB_STALL_EN
    .stall     (stall),
`endif
    .start     (start),
    .opcode    (opcode),
    .funct     (funct),
    .wr_sel    (wr_sel),
    .wd_sel    (wd_sel),
    .reg_write (reg_write),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  logic [7:0] obs;
  assign obs = {busy, reg_write, wr_sel, wd_sel, done, illegal};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] mk(input logic b, input logic rw,
                                    input logic [1:0] wr, input logic [1:0] wd,
                                    input logic d, input logic il);
    return {b, rw, wr, wd, d, il};
  endfunction

  // Reference model: expected outputs for every cycle after start, then one
  // idle cycle. kind: 0 no write, 1 single write, 2 load, 3 pop, 4 illegal.
  task automatic model_txn(input logic [5:0] op, input logic [5:0] fn);
    int kind;
    logic [1:0] wr;
    logic [1:0] wd;
    kind = 4;
    wr   = 2'd0;
    wd   = 2'd0;
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h18 || fn == 6'h1a) kind = 0;
      else begin kind = 1; wr = 2'd3; end
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0a, 6'h0c: kind = 1;
        6'h0f: begin kind = 1; wd = 2'd3; end
        6'h23, 6'h21, 6'h20: kind = 2;
        6'h2b, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02: kind = 0;
        6'h03: begin kind = 1; wr = 2'd2; wd = 2'd2; end
        OP_PUSH: begin kind = 1; wr = 2'd1; end
        OP_POP: kind = 3;
        default: kind = 4;
      endcase
    end
    case (kind)
      0: exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0));
      1: exp_q.push_back(mk(1'b1, 1'b1, wr, wd, 1'b1, 1'b0));
      2: begin
        repeat (MW) exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0));
      end
      3: begin
        repeat (MW) exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0));
      end
      default: exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1));
    endcase
    exp_q.push_back(8'h00);
  endtask

  // ---------------- driver ----------------
  // Entered at a point where the DUT is idle and the clock is low; asserts
  // start for one edge and records n cycles of outputs.
  task automatic drive_txn(input logic [5:0] op, input logic [5:0] fn, input int n);
    start  = 1'b1;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      obs_q.push_back(obs);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", obs, 8'h00);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs, 8'h00);
    end
  endtask

  task automatic test_directed(input logic [5:0] op, input logic [5:0] fn, input string name);
    int n;
    logic [7:0] e;
    logic [7:0] o;
    model_txn(op, fn);
    n = exp_q.size();
    drive_txn(op, fn, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d got %b exp %b", name, i + 1, o, e);
      end
    end
  endtask

  // Keeps start asserted with other instructions while a lw is in flight.
  task automatic test_back_to_back();
    int n;
    int writes;
    logic [7:0] e;
    model_txn(6'h23, 6'h00);
    n = exp_q.size();
    writes = 0;
    start  = 1'b1;
    opcode = 6'h23;
    funct  = 6'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < n - 2) begin
        start  = 1'b1;
        opcode = (i == 0) ? 6'h03 : OP_POP;
        funct  = 6'($urandom_range(0, 63));
      end else begin
        start = 1'b0;
      end
      #1;
      e = exp_q.pop_front();
      if (reg_write === 1'b1) writes++;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL busy_start cycle %0d got %b exp %b", i + 1, obs, e);
      end
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL busy_start_writes got %0d exp 1", writes);
    end
  endtask

  task automatic test_reset_mid();
    start  = 1'b1;
    opcode = 6'h23;
    funct  = 6'h00;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (obs !== mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_wait got %b exp %b", obs, mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_idle got %b exp %b", obs, 8'h00);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_drop cycle %0d got %b exp %b", i, obs, 8'h00);
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [5:0] ops [16];
    logic [5:0] op;
    logic [5:0] fn;
    int n;
    logic [7:0] e;
    logic [7:0] o;
    ops = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f, 6'h23, 6'h21, 6'h20,
            6'h2b, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03, OP_POP};
    for (int t = 0; t < count; t++) begin
      case ($urandom_range(0, 3))
        0: op = ops[$urandom_range(0, 15)];
        1: op = 6'h00;
        2: op = OP_PUSH;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 3))
        0: fn = 6'h08;
        1: fn = 6'h18;
        2: fn = 6'h1a;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      model_txn(op, fn);
      n = exp_q.size();
      drive_txn(op, fn, n);
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random op %h fn %h cycle %0d got %b exp %b", op, fn, i + 1, o, e);
        end
      end
    end
  endtask

`ifdef WB_STALL_EN
  // Three stalled cycles over WRITE1 of a jal push its write out by three.
  task automatic test_stall();
    int n;
    logic [7:0] e;
    model_txn(6'h03, 6'h00);
    repeat (3) exp_q.push_front(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    n = exp_q.size();
    start  = 1'b1;
    opcode = 6'h03;
    funct  = 6'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      stall = (i < 3);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall cycle %0d got %b exp %b", i + 1, obs, e);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
`ifdef WB_STALL_EN
    stall  = 1'b0;
`endif
    test_reset();
    test_directed(6'h00, 6'h20, "alu_rtype");
    test_directed(6'h23, 6'h00, "load_lw");
    test_directed(OP_POP, 6'h00, "pop");
    test_directed(6'h03, 6'h00, "jal");
    test_directed(6'h2b, 6'h00, "store_sw");
    test_directed(6'h3a, 6'h00, "illegal");
    test_directed(6'h0f, 6'h00, "lui");
    test_directed(OP_PUSH, 6'h00, "push");
    test_directed(6'h00, 6'h08, "jr");
    test_back_to_back();
    test_reset_mid();
`ifdef WB_STALL_EN
    test_stall();
`endif
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
